status_cond_unit: RTL and testbench
===================================

# status_cond_unit

Status-register and condition-evaluation stage wrapped around the ALU. It captures the ALU's N/Z/C/V flags for flag-setting instructions (S=1) into a one-entry pending stage, then commits them to the architectural NZCV register one cycle later. It supplies the carry-in for ADC/SBC/RSC back to the ALU. It also evaluates the 4-bit condition field of the instruction in decode, forwarding the newest in-flight flags so back-to-back CMP→branch needs no stall.

## Interface
Parameters:
- none; condition encodings and NZCV bit positions come from the shared package.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction in EX is live this cycle
- ex_s  in  1  S bit of the EX instruction (flag update request)
- alu_n, alu_z, alu_c, alu_v  in  1 each  flag outputs of the ALU for the EX instruction
- stall  in  1  pipeline hold; EX instruction will be replayed
- flush  in  1  kill EX and pending flag writes (branch taken or exception)
- id_cond  in  4  condition field of the instruction in decode
- cond_true  out  1  decode instruction's condition passes
- alu_cin  out  1  carry-in to the ALU for the EX instruction
- psr_nzcv  out  4  architectural flags {N,Z,C,V}, bit 3 = N
- pend_valid  out  1  a flag write is in the pending stage

## Operation
- State: psr_nzcv[3:0], pend_nzcv[3:0], pend_valid.
- Capture: ex_valid & ex_s & !stall & !flush at edge t → pend_nzcv ← {alu_n,alu_z,alu_c,alu_v}, pend_valid ← 1.
- Commit: pend_valid & !stall & !flush at edge → psr_nzcv ← pend_nzcv. pend_valid is then cleared unless a new capture occurs in the same cycle. Commit and capture in the same cycle are both performed.
- Stall: pend and psr hold. No capture, no commit.
- Flush: pend_valid ← 0. psr unchanged. EX flags discarded. Flush has priority over stall.
- Forwarded flags F, in priority order:
  - current EX flags, if ex_valid & ex_s & !flush;
  - else pend_nzcv, if pend_valid;
  - else psr_nzcv.
- cond_true = f(id_cond, F):
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - MI 0100 N; PL 0101 !N
  - VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1; 1111 0 (NV, never)
- alu_cin = C of pend_nzcv if pend_valid, else C of psr_nzcv. The EX instruction's own flags are never used, which avoids a combinational loop through the ALU.

## Timing
- Reset (async, rst_n=0): psr_nzcv=4'b0000, pend_nzcv=4'b0000, pend_valid=0.
  - Combinational outputs at reset: cond_true follows id_cond with F=0000 (so EQ gives 0), alu_cin=0.
  - Reset mid-operation discards the pending write.
- Latency: EX flags visible at cond_true in the same cycle (0), in pend at t+1, in psr_nzcv at t+2.
- Back-to-back flag setters at t and t+1: psr gets the t flags at t+2 and the t+1 flags at t+3. No write is lost.
- Flush in the cycle after capture: the pending write never reaches psr.
- Stall spanning N cycles delays commit by exactly N cycles.
- cond_true and alu_cin are purely combinational from state and inputs.

## Structure
- Shared package cpu_pkg holds:
  - condition code constants (COND_EQ … COND_NV);
  - NZCV bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, cond_eval: combinational (cond[3:0], nzcv[3:0]) → pass. It is reused later by the branch unit.
- Top holds the registers and the forwarding mux.

## Test plan
- Reset, then id_cond=0000 (EQ) → cond_true=0; id_cond=1110 → 1; id_cond=1111 → 0; psr_nzcv=0000, alu_cin=0.
- CMP 0x7FFFFFFF,0x7FFFFFFF: EX flags N=0,Z=1,C=1,V=0 with ex_s=1, id_cond=EQ the same cycle → cond_true=1 (forwarded); pend_valid=1 at t+1; psr_nzcv=0110 at t+2.
- ADD 0xFFFFFFFF+1 with S=1 (C=1,Z=1) at t, ADC in EX at t+1 → alu_cin=1 at t+1; also id_cond=HI at t+1 → cond_true=0.
- Flag write at t, flush at t+1 → psr_nzcv stays 0000, pend_valid=0 at t+2.
- Flag write at t, stall held t+1..t+3 → psr_nzcv updates only at t+5. Capture attempted during the stall is ignored.
- Consecutive S writes 1000 then 0001, with rst_n pulsed low mid-sequence → all state returns to 0000 asynchronously and no commit follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction condition-field encodings and NZCV bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition check: decides whether a 4-bit condition field passes
// for a given set of NZCV flags. Shared with the branch unit.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Status register with a one-entry pending flag stage, ALU carry-in supply and
// decode-stage condition evaluation using the newest in-flight flags.
module status_cond_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] id_cond,
  output logic       cond_true,
  output logic       alu_cin,
  output logic [3:0] psr_nzcv,
  output logic       pend_valid
);

  logic [3:0] pend_nzcv;
  logic [3:0] ex_nzcv;
  logic [3:0] fwd_nzcv;
  logic       ex_sets_flags;

  assign ex_nzcv       = {alu_n, alu_z, alu_c, alu_v};
  assign ex_sets_flags = ex_valid && ex_s;

  // Flush outranks stall; otherwise commit and capture may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr_nzcv   <= 4'b0000;
      pend_nzcv  <= 4'b0000;
      pend_valid <= 1'b0;
    end else if (flush) begin
      pend_valid <= 1'b0;
    end else if (!stall) begin
      if (pend_valid) begin
        psr_nzcv <= pend_nzcv;
      end
      if (ex_sets_flags) begin
        pend_nzcv  <= ex_nzcv;
        pend_valid <= 1'b1;
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    fwd_nzcv = psr_nzcv;
    if (ex_sets_flags && !flush) begin
      fwd_nzcv = ex_nzcv;
    end else if (pend_valid) begin
      fwd_nzcv = pend_nzcv;
    end
  end

  // Carry-in deliberately ignores the EX flags to avoid a loop through the ALU.
  assign alu_cin = pend_valid ? pend_nzcv[FLAG_C] : psr_nzcv[FLAG_C];

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (fwd_nzcv),
    .pass (cond_true)
  );

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit: directed scenarios plus randomized
// traffic compared against a queue-based flag model.
module tb_status_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ex_valid = 1'b0;
  logic       ex_s = 1'b0;
  logic       alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] id_cond = 4'b0000;
  logic       cond_true;
  logic       alu_cin;
  logic [3:0] psr_nzcv;
  logic       pend_valid;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural flags plus a list of writes not yet committed.
  logic [3:0] m_psr = 4'b0000;
  logic [3:0] m_q[$];

  status_cond_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_s       (ex_s),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .stall      (stall),
    .flush      (flush),
    .id_cond    (id_cond),
    .cond_true  (cond_true),
    .alu_cin    (alu_cin),
    .psr_nzcv   (psr_nzcv),
    .pend_valid (pend_valid)
  );

  always #5 clk = ~clk;

  // Conditions come in pairs; the odd member of each pair is the negation.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic logic [3:0] model_fwd();
    if (ex_valid && ex_s && !flush) return {alu_n, alu_z, alu_c, alu_v};
    if (m_q.size() > 0) return m_q[0];
    return m_psr;
  endfunction

  function automatic logic model_cin();
    logic [3:0] f;
    f = (m_q.size() > 0) ? m_q[0] : m_psr;
    return f[1];
  endfunction

  task automatic drive(input logic v, input logic s, input logic [3:0] f,
                       input logic st, input logic fl, input logic [3:0] c);
    ex_valid = v; ex_s = s;
    {alu_n, alu_z, alu_c, alu_v} = f;
    stall = st; flush = fl; id_cond = c;
  endtask

  // Advance the model with the inputs presented this cycle, then cross the edge.
  task automatic clock_edge();
    if (!rst_n) begin
      m_psr = 4'b0000;
      m_q.delete();
    end else if (flush) begin
      m_q.delete();
    end else if (!stall) begin
      if (m_q.size() > 0) m_psr = m_q.pop_front();
      if (ex_valid && ex_s) m_q.push_back({alu_n, alu_z, alu_c, alu_v});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] conds [3];
    logic       exp   [3];
    conds[0] = 4'b0000; exp[0] = 1'b0;
    conds[1] = 4'b1110; exp[1] = 1'b1;
    conds[2] = 4'b1111; exp[2] = 1'b0;
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      id_cond = conds[i];
      #1;
      checks++;
      if (cond_true !== exp[i]) begin
        errors++;
        $display("[TB] FAIL reset_cond%0d: cond_true=%b expected %b", i, cond_true, exp[i]);
      end
    end
    checks++;
    if (psr_nzcv !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_psr: psr_nzcv=%b expected 0000", psr_nzcv);
    end
    checks++;
    if (alu_cin !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_cin: alu_cin=%b expected 0", alu_cin);
    end
    checks++;
    if (pend_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pend: pend_valid=%b expected 0", pend_valid);
    end
    m_psr = 4'b0000; m_q.delete();
    clock_edge();
    rst_n = 1'b1;
    clock_edge();
  endtask

  task automatic test_cmp_forward();
    drive(1, 1, 4'b0110, 0, 0, 4'b0000);
    #1;
    checks++;
    if (cond_true !== 1'b1) begin
      errors++; $display("[TB] FAIL cmp_fwd_eq: cond_true=%b expected 1", cond_true);
    end
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    checks++;
    if (pend_valid !== 1'b1 || psr_nzcv !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL cmp_t1: pend_valid=%b psr=%b expected 1/0000", pend_valid, psr_nzcv);
    end
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b0110 || pend_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cmp_t2: psr=%b pend_valid=%b expected 0110/0", psr_nzcv, pend_valid);
    end
  endtask

  task automatic test_adc_carry();
    drive(1, 1, 4'b1000, 0, 0, 4'b0000);
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    clock_edge();
    drive(1, 1, 4'b0110, 0, 0, 4'b0000);
    clock_edge();
    drive(1, 0, 4'b1001, 0, 0, 4'b1000);
    #1;
    checks++;
    if (alu_cin !== 1'b1) begin
      errors++; $display("[TB] FAIL adc_cin: alu_cin=%b expected 1", alu_cin);
    end
    checks++;
    if (cond_true !== 1'b0) begin
      errors++; $display("[TB] FAIL adc_hi: cond_true=%b expected 0", cond_true);
    end
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    clock_edge();
  endtask

  task automatic test_flush();
    drive(1, 1, 4'b0000, 0, 0, 4'b0000);
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    clock_edge();
    drive(1, 1, 4'b1111, 0, 0, 4'b0000);
    clock_edge();
    checks++;
    if (pend_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_pre: pend_valid=%b expected 1", pend_valid);
    end
    drive(1, 1, 4'b1010, 0, 1, 4'b0000);
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    checks++;
    if (psr_nzcv !== 4'b0000 || pend_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_post: psr=%b pend_valid=%b expected 0000/0", psr_nzcv, pend_valid);
    end
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b0000) begin
      errors++; $display("[TB] FAIL flush_late: psr=%b expected 0000", psr_nzcv);
    end
  endtask

  task automatic test_stall();
    drive(1, 1, 4'b1010, 0, 0, 4'b0000);
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'b0101, 1, 0, 4'b0000);
      clock_edge();
      checks++;
      if (psr_nzcv !== 4'b0000 || pend_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: psr=%b pend_valid=%b expected 0000/1", i, psr_nzcv, pend_valid);
      end
    end
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b1010 || pend_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_commit: psr=%b pend_valid=%b expected 1010/0", psr_nzcv, pend_valid);
    end
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b1010) begin
      errors++; $display("[TB] FAIL stall_ignored: psr=%b expected 1010", psr_nzcv);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 4'b0011, 0, 0, 4'b0000);
    clock_edge();
    drive(1, 1, 4'b1100, 0, 0, 4'b0000);
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    checks++;
    if (psr_nzcv !== 4'b0011 || pend_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: psr=%b pend_valid=%b expected 0011/1", psr_nzcv, pend_valid);
    end
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b1100 || pend_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: psr=%b pend_valid=%b expected 1100/0", psr_nzcv, pend_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 4'b1000, 0, 0, 4'b0000);
    clock_edge();
    drive(1, 1, 4'b0001, 0, 0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (psr_nzcv !== 4'b0000 || pend_valid !== 1'b0 || alu_cin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_now: psr=%b pend_valid=%b cin=%b expected 0000/0/0", psr_nzcv, pend_valid, alu_cin);
    end
    clock_edge();
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
    #2 rst_n = 1'b1;
    clock_edge();
    clock_edge();
    checks++;
    if (psr_nzcv !== 4'b0000 || pend_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_after: psr=%b pend_valid=%b expected 0000/0", psr_nzcv, pend_valid);
    end
  endtask

  task automatic test_random();
    logic exp_ct, exp_cin;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, 4'($urandom),
            $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0, 4'($urandom));
      #1;
      exp_ct  = ref_cond(id_cond, model_fwd());
      exp_cin = model_cin();
      checks++;
      if (cond_true !== exp_ct || alu_cin !== exp_cin) begin
        errors++;
        $display("[TB] FAIL rand_comb%0d: cond_true=%b cin=%b expected %b/%b (cond=%b)",
                 i, cond_true, alu_cin, exp_ct, exp_cin, id_cond);
      end
      clock_edge();
      checks++;
      if (psr_nzcv !== m_psr || pend_valid !== (m_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL rand_state%0d: psr=%b pend_valid=%b expected %b/%b",
                 i, psr_nzcv, pend_valid, m_psr, (m_q.size() != 0));
      end
    end
    drive(0, 0, 4'b0000, 0, 0, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_cmp_forward();
    test_adc_carry();
    test_flush();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
